// File: rtl/pc_unit_pkg.sv
// Shared control encodings for the program-counter unit: next-PC source
// codes, default boot/trap vectors and the two FSM state constants.
package pc_unit_pkg;

   // Next-PC source select; codes 5..7 are reserved and behave as SEQ.
   localparam logic [2:0] NPC_SEQ    = 3'd0;
   localparam logic [2:0] NPC_BRANCH = 3'd1;
   localparam logic [2:0] NPC_JUMP   = 3'd2;
   localparam logic [2:0] NPC_JR     = 3'd3;
   localparam logic [2:0] NPC_ERET   = 3'd4;

   // Default vectors, zero-extended to the configured PC width by users.
   localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_3000;
   localparam logic [31:0] PC_EXC_VEC_DEF   = 32'h0000_4180;

   // Two-state boot sequencer encoding.
   localparam logic [0:0] ST_BOOT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/pc_unit_npc_calc.sv
// Combinational next-PC selection and word-alignment check.
module npc_calc
   import pc_unit_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] i_pc,
   input  logic [ADDR_W-1:0] i_epc,
   input  logic [2:0]        i_npc_sel,
   input  logic              i_br_taken,
   input  logic [ADDR_W-1:0] i_br_offset,
   input  logic [25:0]       i_j_index,
   input  logic [ADDR_W-1:0] i_jr_target,
   output logic [ADDR_W-1:0] o_pc_plus4,
   output logic [ADDR_W-1:0] o_npc,
   output logic              o_misaligned
);

   logic [ADDR_W-1:0] w_pc_plus4;
   logic [ADDR_W-1:0] w_br_target;
   logic [ADDR_W-1:0] w_jump_target;
   logic [ADDR_W-1:0] w_npc;

   // All sums wrap silently at ADDR_W bits.
   assign w_pc_plus4  = i_pc + ADDR_W'(4);
   assign w_br_target = w_pc_plus4 + (i_br_offset << 2);

   // Jump keeps the upper region bits of pc+4 and replaces the low 28 bits;
   // written as an overlay so ADDR_W=28 needs no empty slice.
   always_comb begin
      w_jump_target       = w_pc_plus4;
      w_jump_target[27:0] = {i_j_index, 2'b00};
   end

   // Select the normal next-PC source; reserved codes fall back to pc+4.
   always_comb begin
      w_npc = w_pc_plus4;
      case (i_npc_sel)
         NPC_BRANCH: w_npc = i_br_taken ? w_br_target : w_pc_plus4;
         NPC_JUMP:   w_npc = w_jump_target;
         NPC_JR:     w_npc = i_jr_target;
         NPC_ERET:   w_npc = i_epc;
         default:    w_npc = w_pc_plus4;
      endcase
   end

   assign o_pc_plus4   = w_pc_plus4;
   assign o_npc        = w_npc;
   assign o_misaligned = |w_npc[1:0];

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: boot sequencer, pc/epc registers, trap redirect
// and misaligned-target detection for a multi-cycle controller.
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC_DEF),
   parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(PC_EXC_VEC_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pc_we,
   input  logic [2:0]        npc_sel,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_offset,
   input  logic [25:0]       j_index,
   input  logic [ADDR_W-1:0] jr_target,
   input  logic              exc_req,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic [ADDR_W-1:0] epc,
   output logic              pc_valid,
   output logic              addr_err,
   output logic [0:0]        dbg_state
);

   logic [0:0]        r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_epc;
   logic              r_addr_err;
   logic [ADDR_W-1:0] w_npc;
   logic              w_misaligned;

   npc_calc #(
      .ADDR_W (ADDR_W)
   ) u_npc_calc (
      .i_pc         (r_pc),
      .i_epc        (r_epc),
      .i_npc_sel    (npc_sel),
      .i_br_taken   (br_taken),
      .i_br_offset  (br_offset),
      .i_j_index    (j_index),
      .i_jr_target  (jr_target),
      .o_pc_plus4   (pc_plus4),
      .o_npc        (w_npc),
      .o_misaligned (w_misaligned)
   );

   // Boot/run sequencing and PC update. Reset dominates every input; BOOT
   // always lasts exactly one non-reset edge and ignores pc_we. In RUN a
   // write takes, in order: exception request, misaligned target (trap plus
   // a one-cycle addr_err pulse), then the normal next-PC.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= ST_BOOT;
         r_pc       <= RESET_VEC;
         r_epc      <= '0;
         r_addr_err <= 1'b0;
      end else begin
         r_state    <= ST_RUN;
         r_addr_err <= 1'b0;
         if (r_state == ST_RUN && pc_we) begin
            if (exc_req) begin
               r_epc <= r_pc;
               r_pc  <= EXC_VEC;
            end else if (w_misaligned) begin
               r_epc      <= r_pc;
               r_pc       <= EXC_VEC;
               r_addr_err <= 1'b1;
            end else begin
               r_pc <= w_npc;
            end
         end
      end
   end

   assign pc        = r_pc;
   assign epc       = r_epc;
   assign pc_valid  = (r_state == ST_RUN);
   assign addr_err  = r_addr_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed boot/branch/trap scenarios
// followed by randomized traffic, checked against a behavioural model
// through an expected-value queue drained by an independent monitor.
module tb_pc_unit;

  localparam int W = 98;  // {pc, epc, pc_plus4, pc_valid, addr_err}
  localparam logic [31:0] RV = 32'h0000_3000;
  localparam logic [31:0] EV = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_we;
  logic [2:0]  npc_sel;
  logic        br_taken;
  logic [31:0] br_offset;
  logic [25:0] j_index;
  logic [31:0] jr_target;
  logic        exc_req;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] epc;
  logic        pc_valid;
  logic        addr_err;
  logic [0:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  bit          m_boot;
  bit          m_aerr;

  pc_unit dut (
    .clk       (clk),
    .rst       (rst),
    .pc_we     (pc_we),
    .npc_sel   (npc_sel),
    .br_taken  (br_taken),
    .br_offset (br_offset),
    .j_index   (j_index),
    .jr_target (jr_target),
    .exc_req   (exc_req),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .epc       (epc),
    .pc_valid  (pc_valid),
    .addr_err  (addr_err),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Architectural target by plain arithmetic on the instruction fields.
  function automatic logic [31:0] ref_target(input logic [31:0] cur_pc, input logic [31:0] cur_epc,
                                             input int sel, input bit taken, input logic [31:0] off,
                                             input logic [25:0] jidx, input logic [31:0] jr);
    logic [31:0] seq;
    seq = cur_pc + 32'd4;
    case (sel)
      1: return taken ? seq + off * 32'd4 : seq;
      2: return (seq & 32'hF000_0000) | (32'(jidx) * 32'd4);
      3: return jr;
      4: return cur_epc;
      default: return seq;
    endcase
  endfunction

  // driver: one clock of stimulus, model update, expected push
  task automatic cyc(input bit r, input bit we, input int sel, input bit taken,
                     input logic [31:0] off, input logic [25:0] jidx,
                     input logic [31:0] jr, input bit exc);
    logic [31:0] t;
    @(negedge clk);
    rst = r; pc_we = we; npc_sel = 3'(sel); br_taken = taken;
    br_offset = off; j_index = jidx; jr_target = jr; exc_req = exc;
    @(posedge clk);
    if (!r) begin
      m_boot = 1; m_pc = RV; m_epc = 32'd0; m_aerr = 0;
    end else begin
      m_aerr = 0;
      if (!m_boot && we) begin
        t = ref_target(m_pc, m_epc, sel, taken, off, jidx, jr);
        if (exc || (t % 4) != 0) begin
          m_aerr = !exc;
          m_epc  = m_pc;
          m_pc   = EV;
        end else begin
          m_pc = t;
        end
      end
      m_boot = 0;
    end
    exp_q.push_back({m_pc, m_epc, m_pc + 32'd4, !m_boot, m_aerr});
  endtask

  task automatic jr_to(input logic [31:0] a);
    cyc(1, 1, 3, 0, 32'd0, 26'd0, a, 0);
  endtask

  // scoreboard monitor
  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mon_pc",       pc,               e[97:66]);
        chk("mon_epc",      epc,              e[65:34]);
        chk("mon_pc_plus4", pc_plus4,         e[33:2]);
        chk("mon_pc_valid", {31'd0, pc_valid}, {31'd0, e[1]});
        chk("mon_addr_err", {31'd0, addr_err}, {31'd0, e[0]});
      end
    end
  end

  // stimulus
  initial begin : stim
    rst = 0; pc_we = 0; npc_sel = 0; br_taken = 0; br_offset = 0;
    j_index = 0; jr_target = 0; exc_req = 0;

    // reset and boot
    cyc(0, 1, 3, 0, 0, 0, 32'h0000_3100, 0);
    #2; chk("boot_c1_pc", pc, 32'h3000); chk("boot_c1_valid", {31'd0, pc_valid}, 32'd0);
    cyc(0, 1, 3, 0, 0, 0, 32'h0000_3100, 0);
    cyc(1, 1, 3, 0, 0, 0, 32'h0000_3100, 0);
    #2; chk("boot_c2_pc", pc, 32'h3000); chk("boot_c2_valid", {31'd0, pc_valid}, 32'd1);
    cyc(1, 1, 3, 0, 0, 0, 32'h0000_3100, 0);
    #2; chk("boot_c3_pc", pc, 32'h3100);

    // sequential and hold
    jr_to(32'h3000);
    cyc(1, 1, 0, 0, 0, 0, 0, 0); #2; chk("seq_we1_pc", pc, 32'h3004);
    cyc(1, 0, 0, 0, 0, 0, 0, 1); #2; chk("seq_hold_pc", pc, 32'h3004);
    cyc(1, 1, 0, 0, 0, 0, 0, 0); #2; chk("seq_we1b_pc", pc, 32'h3008);

    // exception with ERET, then return
    cyc(1, 1, 4, 0, 0, 0, 0, 1);
    #2; chk("exc_pc", pc, 32'h4180); chk("exc_epc", epc, 32'h3008);
    cyc(1, 1, 4, 0, 0, 0, 0, 0); #2; chk("eret_pc", pc, 32'h3008);

    // branch and jump
    jr_to(32'h3010);
    cyc(1, 1, 1, 1, 32'hFFFF_FFFC, 0, 0, 0); #2; chk("br_taken_pc", pc, 32'h3004);
    jr_to(32'h3010);
    cyc(1, 1, 1, 0, 32'hFFFF_FFFC, 0, 0, 0); #2; chk("br_not_taken_pc", pc, 32'h3014);
    cyc(1, 1, 2, 0, 0, 26'h000_0C10, 0, 0); #2; chk("jump_pc", pc, 32'h3040);

    // misaligned register jump
    cyc(1, 1, 3, 0, 0, 0, 32'h3002, 0);
    #2; chk("mis_pc", pc, 32'h4180); chk("mis_epc", epc, 32'h3040);
    chk("mis_aerr_on", {31'd0, addr_err}, 32'd1);
    cyc(1, 0, 3, 0, 0, 0, 32'h3002, 0);
    #2; chk("mis_aerr_off", {31'd0, addr_err}, 32'd0); chk("mis_hold_pc", pc, 32'h4180);

    // wrap-around, then reset during a trap request
    jr_to(32'hFFFF_FFFC);
    cyc(1, 1, 0, 0, 0, 0, 0, 0); #2; chk("wrap_pc", pc, 32'h0000_0000);
    cyc(0, 1, 4, 0, 0, 0, 0, 1);
    #2; chk("rst_trap_pc", pc, 32'h3000); chk("rst_trap_epc", epc, 32'd0);
    chk("rst_trap_valid", {31'd0, pc_valid}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] jr;
      jr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) jr = jr | 32'($urandom_range(1, 3));
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
          $urandom_range(0, 1) == 1, 32'($urandom_range(0, 255)) - 32'd128,
          26'($urandom), jr, $urandom_range(0, 9) == 0);
    end

    // drain, bounded
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
